// File: rtl/b01_collect_pkg.sv
// Shared types for the b01 result collector.
// Holds the output buffer state encoding and counter sizing.
package b01_collect_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } buf_state_t;

   function automatic int CNT_W(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/b01_shift_in.sv
// Serial-to-parallel word assembler, LSB first.
// Pulses word_done with the full word on its last bit.
module b01_shift_in
   import b01_collect_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             bit_in,
   input  logic             ovf_in,
   input  logic             bit_valid,
   output logic             word_done,
   output logic [WIDTH-1:0] word,
   output logic             ovf,
   output logic             busy
);

   localparam int CW = CNT_W(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic             ovf_q, ovf_d;

   // Insert the sampled bit and advance or wrap the bit counter
   always_comb begin
      cnt_d     = cnt_q;
      sh_d      = sh_q;
      ovf_d     = ovf_q;
      word_done = 1'b0;
      if (bit_valid) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CW'(i)) sh_d[i] = bit_in;
         end
         if (cnt_q == LAST) begin
            word_done = 1'b1;
            cnt_d     = '0;
            ovf_d     = 1'b0;
         end else begin
            cnt_d = cnt_q + 1'b1;
            ovf_d = ovf_q | ovf_in;
         end
      end
   end

   assign word = sh_d;
   assign ovf  = ovf_q | ovf_in;
   assign busy = (cnt_q != '0);

   // Assembly state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         sh_q  <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sh_q  <= sh_d;
         ovf_q <= ovf_d;
      end
   end

endmodule

// File: rtl/b01_result_collector.sv
// Packs the comparator bit stream into words and hands them out
// through a 2-slot valid/ready buffer with a saturating drop count.
module b01_result_collector
   import b01_collect_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DROP_W = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              bit_in,
   input  logic              ovf_in,
   input  logic              bit_valid,
   output logic [WIDTH-1:0]  word_out,
   output logic              ovf_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DROP_W-1:0] drop_cnt,
   output logic              busy
);

   logic             push;
   logic [WIDTH-1:0] new_word;
   logic             new_ovf;
   logic             pop;

   buf_state_t        state_q, state_d;
   logic [WIDTH-1:0]  o_word_q, o_word_d;
   logic              o_ovf_q, o_ovf_d;
   logic [WIDTH-1:0]  h_word_q, h_word_d;
   logic              h_ovf_q, h_ovf_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   b01_shift_in #(
      .WIDTH(WIDTH)
   ) u_shift_in (
      .clock    (clock),
      .reset_n  (reset_n),
      .bit_in   (bit_in),
      .ovf_in   (ovf_in),
      .bit_valid(bit_valid),
      .word_done(push),
      .word     (new_word),
      .ovf      (new_ovf),
      .busy     (busy)
   );

   assign pop = (state_q != EMPTY) && out_ready;

   // Buffer next-state: O slot feeds outputs, H slot holds overflow
   always_comb begin
      state_d  = state_q;
      o_word_d = o_word_q;
      o_ovf_d  = o_ovf_q;
      h_word_d = h_word_q;
      h_ovf_d  = h_ovf_q;
      drop_d   = drop_q;
      case (state_q)
         EMPTY: begin
            if (push) begin
               state_d  = ONE;
               o_word_d = new_word;
               o_ovf_d  = new_ovf;
            end
         end
         ONE: begin
            if (push && !pop) begin
               state_d  = TWO;
               h_word_d = new_word;
               h_ovf_d  = new_ovf;
            end else if (push && pop) begin
               o_word_d = new_word;
               o_ovf_d  = new_ovf;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (pop && push) begin
               o_word_d = h_word_q;
               o_ovf_d  = h_ovf_q;
               h_word_d = new_word;
               h_ovf_d  = new_ovf;
            end else if (pop) begin
               state_d  = ONE;
               o_word_d = h_word_q;
               o_ovf_d  = h_ovf_q;
            end else if (push) begin
               if (drop_q != '1) drop_d = drop_q + 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // Buffer and drop counter registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= EMPTY;
         o_word_q <= '0;
         o_ovf_q  <= 1'b0;
         h_word_q <= '0;
         h_ovf_q  <= 1'b0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         o_word_q <= o_word_d;
         o_ovf_q  <= o_ovf_d;
         h_word_q <= h_word_d;
         h_ovf_q  <= h_ovf_d;
         drop_q   <= drop_d;
      end
   end

   assign word_out  = o_word_q;
   assign ovf_out   = o_ovf_q;
   assign out_valid = (state_q != EMPTY);
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_b01_result_collector.sv
// Directed bench for b01_result_collector, WIDTH=4.
// A second instance with DROP_W=2 exercises counter saturation.
module tb_b01_result_collector;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       bit_in, ovf_in, bit_valid;
   logic       out_ready, out_ready2;
   logic [3:0] word_out, word_out2;
   logic       ovf_out, ovf_out2;
   logic       out_valid, out_valid2;
   logic [7:0] drop_cnt;
   logic [1:0] drop_cnt2;
   logic       busy, busy2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   b01_result_collector #(.WIDTH(4), .DROP_W(8)) dut (
      .clock    (clk),
      .reset_n  (reset_n),
      .bit_in   (bit_in),
      .ovf_in   (ovf_in),
      .bit_valid(bit_valid),
      .word_out (word_out),
      .ovf_out  (ovf_out),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .drop_cnt (drop_cnt),
      .busy     (busy)
   );

   b01_result_collector #(.WIDTH(4), .DROP_W(2)) dut2 (
      .clock    (clk),
      .reset_n  (reset_n),
      .bit_in   (bit_in),
      .ovf_in   (ovf_in),
      .bit_valid(bit_valid),
      .word_out (word_out2),
      .ovf_out  (ovf_out2),
      .out_valid(out_valid2),
      .out_ready(out_ready2),
      .drop_cnt (drop_cnt2),
      .busy     (busy2)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic b, input logic o);
      bit_in    = b;
      ovf_in    = o;
      bit_valid = 1'b1;
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      ovf_in    = 1'b0;
   endtask

   task automatic send_word(input logic [3:0] w, input logic [3:0] m);
      for (int i = 0; i < 4; i++) send_bit(w[i], m[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n    = 1'b0;
      bit_in     = 1'b0;
      ovf_in     = 1'b0;
      bit_valid  = 1'b0;
      out_ready  = 1'b0;
      out_ready2 = 1'b0;
      idle(2);
      check("rst_word", word_out, 0);
      check("rst_ovf", ovf_out, 0);
      check("rst_valid", out_valid, 0);
      check("rst_drop", drop_cnt, 0);
      check("rst_busy", busy, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // basic word 1,0,1,1 -> D
      out_ready = 1'b1;
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      check("t1_busy", busy, 1);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      check("t1_word", word_out, 4'hD);
      check("t1_ovf", ovf_out, 0);
      check("t1_valid", out_valid, 1);
      check("t1_busy0", busy, 0);
      idle(1);
      check("t1_valid_1cyc", out_valid, 0);

      // gapped bits 0,1,0,0 with ovf on bit 2 -> 2, ovf
      send_bit(1'b0, 1'b0);
      idle(3);
      send_bit(1'b1, 1'b0);
      idle(3);
      check("t2_gap_valid", out_valid, 0);
      send_bit(1'b0, 1'b1);
      idle(3);
      send_bit(1'b0, 1'b0);
      check("t2_word", word_out, 4'h2);
      check("t2_ovf", ovf_out, 1);
      check("t2_valid", out_valid, 1);
      send_word(4'hF, 4'h0);
      check("t2_next_word", word_out, 4'hF);
      check("t2_next_ovf", ovf_out, 0);
      idle(1);

      // back-pressure: 1,2,3 with ready low -> 3 dropped
      out_ready = 1'b0;
      send_word(4'h1, 4'h0);
      send_word(4'h2, 4'h0);
      send_word(4'h3, 4'h0);
      check("t3_valid", out_valid, 1);
      check("t3_word", word_out, 4'h1);
      check("t3_drop", drop_cnt, 1);
      idle(2);
      check("t3_hold_word", word_out, 4'h1);
      check("t3_hold_valid", out_valid, 1);
      out_ready = 1'b1;
      idle(1);
      check("t3_pop2_word", word_out, 4'h2);
      check("t3_pop2_valid", out_valid, 1);
      idle(1);
      check("t3_empty", out_valid, 0);
      check("t3_drop_keep", drop_cnt, 1);

      // TWO with simultaneous pop and push
      out_ready = 1'b0;
      send_word(4'h4, 4'h0);
      send_word(4'h5, 4'h1);
      check("t4_word4", word_out, 4'h4);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      out_ready = 1'b1;
      send_bit(1'b0, 1'b0);
      check("t4_word5", word_out, 4'h5);
      check("t4_ovf5", ovf_out, 1);
      check("t4_drop", drop_cnt, 1);
      idle(1);
      check("t4_word6", word_out, 4'h6);
      check("t4_ovf6", ovf_out, 0);
      check("t4_valid6", out_valid, 1);
      idle(1);
      check("t4_empty", out_valid, 0);

      // reset in the middle of a word
      out_ready = 1'b0;
      send_word(4'h9, 4'h0);
      check("t5_pre_word", word_out, 4'h9);
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b0);
      check("t5_pre_busy", busy, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("t5_rst_word", word_out, 0);
      check("t5_rst_valid", out_valid, 0);
      check("t5_rst_drop", drop_cnt, 0);
      check("t5_rst_busy", busy, 0);
      @(negedge clk);
      reset_n   = 1'b1;
      out_ready = 1'b1;
      send_word(4'h5, 4'h0);
      check("t5_clean_word", word_out, 4'h5);
      check("t5_clean_ovf", ovf_out, 0);
      check("t5_clean_valid", out_valid, 1);

      // saturation with DROP_W=2
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_rst_drop2", drop_cnt2, 0);
      @(negedge clk);
      reset_n   = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_word(4'(i + 1), 4'h0);
      check("t6_drop2_mid", drop_cnt2, 2);
      send_word(4'hA, 4'h0);
      send_word(4'hB, 4'h0);
      check("t6_drop2_sat", drop_cnt2, 3);
      check("t6_drop8", drop_cnt, 4);
      check("t6_word", word_out2, 4'h1);
      idle(2);
      check("t6_drop2_hold", drop_cnt2, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/b01_result_collector.md
Name: b01_result_collector

Overview:
Downstream stage of the b01 serial comparator FSM. Samples its serial OUTP/OVERFLW bit stream and packs OUTP bits LSB-first into WIDTH-bit words. Delivers each word with a sticky overflow flag over a valid/ready interface. Absorbs consumer back-pressure with a 2-slot buffer and counts any words it has to drop.

Parameters:
WIDTH, 8, bits per assembled word (legal range 2..32)
DROP_W, 8, width of saturating dropped-word counter

Ports:
clock  input  1  single clock, all state updates on posedge
reset_n  input  1  asynchronous active-low reset
bit_in  input  1  serial OUTP bit from comparator
ovf_in  input  1  OVERFLW flag accompanying bit_in
bit_valid  input  1  bit_in/ovf_in sampled this cycle when high
word_out  output  WIDTH  assembled word, bit 0 = first bit received
ovf_out  output  1  OR of ovf_in over all bits of word_out
out_valid  output  1  word_out/ovf_out valid
out_ready  input  1  consumer accepts when out_valid & out_ready
drop_cnt  output  DROP_W  count of words dropped, saturating
busy  output  1  partial word in progress (bit count != 0)

Behaviour:
- Clock and reset: one clock. reset_n is asynchronous and active-low; it is the only reset. Assertion at any time, including mid-word, clears all state immediately. The partial word is discarded, never emitted.
- Reset values: word_out=0, ovf_out=0, out_valid=0, drop_cnt=0, busy=0, bit counter=0, both buffer slots empty.
- Assembly:
  - On each cycle with bit_valid=1, bit_in is written into position cnt of the shift register.
  - ovf_acc <= ovf_acc | ovf_in.
  - cnt increments.
  - Cycles with bit_valid=0 hold all assembly state (gaps allowed anywhere).
- Completion:
  - A word completes on the valid bit with cnt==WIDTH-1.
  - cnt wraps to 0 and ovf_acc clears in that same cycle.
  - The next valid bit starts a new word with no dead cycle.
- Latency: the completed word appears on word_out with out_valid=1 in the cycle after its last bit is sampled, provided the output slot is free or being popped.
- Buffer FSM, states EMPTY / ONE / TWO. Slot O drives the outputs; slot H is the hold slot.
  - push = word completes this cycle; pop = out_valid & out_ready.
  - EMPTY: push -> ONE (word into O).
  - ONE:
    - push & !pop -> TWO (word into H).
    - push & pop -> ONE (new word into O).
    - pop only -> EMPTY.
    - neither -> ONE.
  - TWO:
    - pop & push -> TWO (H->O, new word into H, no drop).
    - pop only -> ONE (H->O).
    - push & !pop -> TWO; the new word is dropped and drop_cnt increments.
    - neither -> TWO.
- drop_cnt saturates at 2^DROP_W-1 and never wraps.
- Stability: word_out/ovf_out are held stable while out_valid=1 and out_ready=0. out_valid never deasserts without a pop.
- out_valid=1 exactly in states ONE and TWO.
- busy = (cnt != 0).
- Arithmetic: cnt is clog2(WIDTH) bits; no other arithmetic.

Decomposition:
- Package b01_collect_pkg holds:
  - buf_state_t enum {EMPTY, ONE, TWO}
  - CNT_W function, clog2 of WIDTH
- One natural sub-module: b01_shift_in. It holds cnt, the shift register, ovf_acc and busy, and outputs a one-cycle word_done pulse with word and ovf.
- The top level holds the 2-slot buffer FSM and drop counter.

Test Plan:
- WIDTH=4, out_ready=1: bits 1,0,1,1 with ovf all 0 on consecutive cycles -> next cycle word_out=4'hD, ovf_out=0, out_valid=1 for 1 cycle.
- WIDTH=4: bits 0,1,0,0 with ovf_in=1 only on bit 2, bit_valid gapped with 3 idle cycles between bits -> word_out=4'h2, ovf_out=1; the following word has ovf_out=0.
- out_ready=0, three words streamed back to back (0x1, 0x2, 0x3) -> out_valid held with word_out=0x1, drop_cnt=1. Then out_ready=1 -> 0x1 and 0x2 delivered in consecutive cycles, 0x3 never appears.
- State TWO with pop and push in the same cycle -> no drop, drop_cnt unchanged, word order preserved.
- reset_n pulsed low after 2 bits of a word -> all outputs 0 asynchronously. The next 4 valid bits form a clean word, and the partial bits do not appear.
- DROP_W=2, out_ready=0, 6 words pushed -> drop_cnt reaches 3 and stays at 3.
